// File: rtl/tiny_fir_tap_loader_pkg.sv
// tiny_fir_pkg: shared FSM state type and address-width helper for the tiny FIR tap loader.
package tiny_fir_pkg;
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT_ACK, S_DONE} loader_state_t;
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/tiny_fir_tap_loader_if.sv
// tiny_fir_tap_loader_if: host config port plus FIR tap stream; master is the loader side.
interface tiny_fir_tap_loader_if #(
    parameter int G_NUM_TAPS  = 16,
    parameter int G_TAP_WIDTH = 16
) ();
    import tiny_fir_pkg::*;
    logic [clog2_min1(G_NUM_TAPS)-1:0] cfg_wr_addr;
    logic [G_TAP_WIDTH-1:0]            cfg_wr_data;
    logic                              cfg_wr_en;
    logic                              cfg_wr_err;
    logic                              commit;
    logic                              busy;
    logic [G_TAP_WIDTH-1:0]            tap_dout;
    logic                              tap_dout_valid;
    logic                              tap_dout_ready;
    logic                              fir_taps_done;
    logic                              load_done;
    modport master (
        input  cfg_wr_addr, cfg_wr_data, cfg_wr_en, commit, tap_dout_ready, fir_taps_done,
        output cfg_wr_err, busy, tap_dout, tap_dout_valid, load_done
    );
    modport slave (
        output cfg_wr_addr, cfg_wr_data, cfg_wr_en, commit, tap_dout_ready, fir_taps_done,
        input  cfg_wr_err, busy, tap_dout, tap_dout_valid, load_done
    );
endinterface

// File: rtl/tiny_fir_tap_loader_shadow.sv
// tiny_fir_tap_shadow: resettable coefficient bank, one write port, combinational read port.
module tiny_fir_tap_shadow #(
    parameter int N  = 16,
    parameter int W  = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          wr_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);
    logic [W-1:0] mem [N];
    always_ff @(posedge clk)
        if (reset) mem <= '{default: '0};
        else if (wr_en) mem[wr_addr] <= wr_data;
    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/tiny_fir_tap_loader.sv
// tiny_fir_tap_loader: streams the shadow coefficient bank to the FIR on commit, then awaits its ack.
// Define TINY_FIR_TAP_LOADER_REVERSE_EN to stream from the last index down to 0.
module tiny_fir_tap_loader
    import tiny_fir_pkg::*;
#(
    parameter int G_NUM_TAPS  = 16,
    parameter int G_TAP_WIDTH = 16
) (
    input logic clk,
    input logic reset,
    tiny_fir_tap_loader_if.master bus
);
    localparam int AW = clog2_min1(G_NUM_TAPS);
    localparam logic [AW:0] NUM = (AW+1)'(G_NUM_TAPS);
`ifdef TINY_FIR_TAP_LOADER_REVERSE_EN
    localparam logic [AW-1:0] FIRST = AW'(G_NUM_TAPS - 1);
    localparam logic [AW-1:0] FINAL = '0;
`else
    localparam logic [AW-1:0] FIRST = '0;
    localparam logic [AW-1:0] FINAL = AW'(G_NUM_TAPS - 1);
`endif
    loader_state_t state, state_nxt;
    logic [AW-1:0] idx, idx_nxt;
    logic [G_TAP_WIDTH-1:0] rd_data;
    logic go, wr_ok, hs, last, load;
    assign go    = state == S_IDLE && bus.commit;
    assign wr_ok = bus.cfg_wr_en && state == S_IDLE && {1'b0, bus.cfg_wr_addr} < NUM;
    assign hs    = state == S_STREAM && bus.tap_dout_ready;
    assign last  = idx == FINAL;
    assign load  = go || (hs && !last);
`ifdef TINY_FIR_TAP_LOADER_REVERSE_EN
    assign idx_nxt = go ? FIRST : idx - 1'b1;
`else
    assign idx_nxt = go ? FIRST : idx + 1'b1;
`endif
    tiny_fir_tap_shadow #(.N(G_NUM_TAPS), .W(G_TAP_WIDTH), .AW(AW)) u_shadow (
        .clk(clk), .reset(reset),
        .wr_addr(bus.cfg_wr_addr), .wr_data(bus.cfg_wr_data), .wr_en(wr_ok),
        .rd_addr(idx_nxt), .rd_data(rd_data)
    );
    always_ff @(posedge clk)
        state <= reset ? S_IDLE : state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     state_nxt = bus.commit ? S_STREAM : S_IDLE;
            S_STREAM:   state_nxt = hs && last ? S_WAIT_ACK : S_STREAM;
            S_WAIT_ACK: state_nxt = bus.fir_taps_done ? S_DONE : S_WAIT_ACK;
            default:    state_nxt = S_IDLE;
        endcase
    end
    always_comb begin
        bus.busy           = state == S_STREAM || state == S_WAIT_ACK;
        bus.tap_dout_valid = state == S_STREAM;
        bus.load_done      = state == S_DONE;
    end
    // A write landing in the commit cycle is forwarded so the first beat already sees it.
    always_ff @(posedge clk)
        if (reset) begin
            idx            <= '0;
            bus.tap_dout   <= '0;
            bus.cfg_wr_err <= 1'b0;
        end else begin
            if (load) begin
                idx          <= idx_nxt;
                bus.tap_dout <= (wr_ok && bus.cfg_wr_addr == idx_nxt) ? bus.cfg_wr_data : rd_data;
            end
            bus.cfg_wr_err <= (bus.cfg_wr_err && !go) || (bus.cfg_wr_en && !wr_ok);
        end
endmodule

// File: tb/tb_tiny_fir_tap_loader.sv
// tb_tiny_fir_tap_loader: scoreboard bench for the tap loader (16-tap and 12-tap instances).
// Honours TINY_FIR_TAP_LOADER_REVERSE_EN for the expected streaming order.
module tb_tiny_fir_tap_loader;
    localparam int N = 16, N12 = 12, W = 16;
    logic clk = 0, reset = 1;
    always #5 clk = ~clk;

    tiny_fir_tap_loader_if #(.G_NUM_TAPS(N), .G_TAP_WIDTH(W)) b16 ();
    tiny_fir_tap_loader_if #(.G_NUM_TAPS(N12), .G_TAP_WIDTH(W)) b12 ();
    tiny_fir_tap_loader #(.G_NUM_TAPS(N), .G_TAP_WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(b16.master));
    tiny_fir_tap_loader #(.G_NUM_TAPS(N12), .G_TAP_WIDTH(W)) dut12 (.clk(clk), .reset(reset), .bus(b12.master));

    int tests = 0, fails = 0, rdy_mode = 0, xfer12 = 0;
    logic [W-1:0] sh [N];
    logic [W-1:0] sh12 [N12];
    logic [W-1:0] exp_q[$], exp12[$];
    int done_q[$];
    bit m_busy = 0, m_err = 0, hold = 0;
    logic [W-1:0] held;

    function automatic int ord(int k, int n);
`ifdef TINY_FIR_TAP_LOADER_REVERSE_EN
        return n - 1 - k;
`else
        return k;
`endif
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(bit wen, int addr, logic [W-1:0] data, bit com);
        bit drop = 0;
        b16.cfg_wr_en = wen; b16.cfg_wr_addr = 4'(addr); b16.cfg_wr_data = data; b16.commit = com;
        if (wen) begin
            if (!m_busy && addr < N) sh[addr] = data;
            else drop = 1;
        end
        if (com && !m_busy) begin
            for (int k = 0; k < N; k++) exp_q.push_back(sh[ord(k, N)]);
            m_busy = 1;
            m_err = 0;
        end
        if (drop) m_err = 1;
        tick();
        b16.cfg_wr_en = 0; b16.commit = 0;
    endtask

    task automatic finish_stream(int ack_delay, output int n);
        n = 0;
        do begin tick(); n++; end while (exp_q.size() > 0 && n < 400);
        chk("stream_drained", exp_q.size(), 0);
        exp_q.delete();
        rdy_mode = 0;
        @(negedge clk);
        chk("wait_ack_valid", b16.tap_dout_valid, 0);
        chk("wait_ack_busy", b16.busy, 1);
        repeat (ack_delay) tick();
        b16.fir_taps_done = 1; done_q.push_back(1);
        tick();
        b16.fir_taps_done = 0;
        @(negedge clk);
        chk("load_done_lat", b16.load_done, 1);
        chk("busy_in_done", b16.busy, 0);
        tick();
        @(negedge clk);
        chk("load_done_pulse", b16.load_done, 0);
        chk("busy_after", b16.busy, 0);
        chk("done_popped", done_q.size(), 0);
        m_busy = 0;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        b16.tap_dout_ready = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : rdy_mode == 1;
    end

    always @(negedge clk) begin
        if (b16.tap_dout_valid && b16.tap_dout_ready && !reset) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_xfer: got %0h expected none", b16.tap_dout);
            end else chk("tap_dout", b16.tap_dout, exp_q.pop_front());
        end
        if (hold && !reset) begin
            chk("hold_valid", b16.tap_dout_valid, 1);
            chk("hold_data", b16.tap_dout, held);
        end
        hold = b16.tap_dout_valid && !b16.tap_dout_ready && !reset;
        held = b16.tap_dout;
        if (b16.load_done) begin
            if (done_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_load_done: got 1 expected 0");
            end else void'(done_q.pop_front());
        end
    end

    always @(negedge clk)
        if (b12.tap_dout_valid && b12.tap_dout_ready && !reset) begin
            xfer12++;
            if (exp12.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_xfer12: got %0h expected none", b12.tap_dout);
            end else chk("tap_dout12", b12.tap_dout, exp12.pop_front());
        end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        b16.cfg_wr_en = 0; b16.cfg_wr_addr = 0; b16.cfg_wr_data = 0; b16.commit = 0; b16.fir_taps_done = 0;
        b12.cfg_wr_en = 0; b12.cfg_wr_addr = 0; b12.cfg_wr_data = 0; b12.commit = 0; b12.fir_taps_done = 0;
        b12.tap_dout_ready = 0;
        for (int i = 0; i < N; i++) sh[i] = '0;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_valid", b16.tap_dout_valid, 0);
        chk("rst_busy", b16.busy, 0);
        chk("rst_dout", b16.tap_dout, 0);
        chk("rst_done", b16.load_done, 0);
        chk("rst_err", b16.cfg_wr_err, 0);
        chk("rst_valid12", b12.tap_dout_valid, 0);
        reset = 0;
        tick();
        // 12-tap instance: out-of-range write, exact-length stream
        for (int k = 0; k < N12; k++) begin
            sh12[k] = 16'($urandom);
            b12.cfg_wr_en = 1; b12.cfg_wr_addr = 4'(k); b12.cfg_wr_data = sh12[k];
            tick();
        end
        b12.cfg_wr_addr = 4'(13); b12.cfg_wr_data = 16'hbeef;
        tick();
        b12.cfg_wr_en = 0;
        @(negedge clk);
        chk("err12_set", b12.cfg_wr_err, 1);
        b12.tap_dout_ready = 1; b12.commit = 1;
        for (int k = 0; k < N12; k++) exp12.push_back(sh12[ord(k, N12)]);
        tick();
        b12.commit = 0;
        @(negedge clk);
        chk("err12_clear", b12.cfg_wr_err, 0);
        n = 0;
        do begin tick(); n++; end while (exp12.size() > 0 && n < 200);
        repeat (3) tick();
        @(negedge clk);
        chk("xfer12", xfer12, N12);
        chk("valid12_low", b12.tap_dout_valid, 0);
        b12.fir_taps_done = 1;
        tick();
        b12.fir_taps_done = 0;
        @(negedge clk);
        chk("load_done12", b12.load_done, 1);
        b12.tap_dout_ready = 0;
        // Ordered burst with ready held high
        for (int i = 0; i < N; i++) cyc(1, i, 16'h0100 + 16'(i), 0);
        rdy_mode = 1;
        @(negedge clk);
        chk("valid_pre", b16.tap_dout_valid, 0);
        cyc(0, 0, 0, 1);
        @(negedge clk);
        chk("valid_rise", b16.tap_dout_valid, 1);
        chk("busy_rise", b16.busy, 1);
        finish_stream(3, n);
        chk("burst_len", n, N);
        // Random backpressure, early ack, writes and commit while busy
        for (int i = 0; i < N; i++) cyc(1, i, 16'($urandom), 0);
        rdy_mode = 2;
        cyc(0, 0, 0, 1);
        b16.fir_taps_done = 1;
        cyc(1, 3, 16'hdead, 0);
        b16.fir_taps_done = 0;
        cyc(0, 0, 0, 1);
        finish_stream(1, n);
        chk("err_sticky", b16.cfg_wr_err, m_err);
        // Write and commit in the same cycle: write lands first, commit clears the error
        rdy_mode = 1;
        cyc(1, ord(0, N), 16'h5a5a, 1);
        @(negedge clk);
        chk("err_clear", b16.cfg_wr_err, m_err);
        finish_stream(0, n);
        // Reset after the 5th transfer
        cyc(0, 0, 0, 1);
        n = 0;
        do begin tick(); n++; end while (exp_q.size() > N - 5 && n < 100);
        rdy_mode = 0;
        reset = 1;
        exp_q.delete(); done_q.delete();
        for (int i = 0; i < N; i++) sh[i] = '0;
        m_busy = 0; m_err = 0;
        tick();
        reset = 0;
        @(negedge clk);
        chk("rst_mid_valid", b16.tap_dout_valid, 0);
        chk("rst_mid_busy", b16.busy, 0);
        chk("rst_mid_dout", b16.tap_dout, 0);
        repeat (5) tick();
        rdy_mode = 2;
        cyc(0, 0, 0, 1);
        finish_stream(2, n);
        chk("exp_q_left", exp_q.size(), 0);
        chk("exp12_left", exp12.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
